// File: rtl/tokenizer.sv
// Byte FIFO plus classifier that turns a raw UART byte stream into character / word-complete / end-of-line tokens.
// Optional build macro TOKENIZER_COMMENT_EN enables backslash line comments.
module tokenizer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_next,
  output logic [7:0] o_data,
  output logic       o_ready,
  output logic       o_wc,
  output logic       o_eol,
  output logic       o_err,
  output logic       o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(WIDTH + 1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          r_in_word, r_last_cr, r_trunc;
  logic [LW-1:0] r_len;
  state_t        r_state, w_state_next;
  logic [7:0]    r_data;
  logic          r_wc, r_eol, r_err;
`ifdef TOKENIZER_COMMENT_EN
  logic          r_comment, w_comment_next;
`endif

  logic          w_push, w_pop, w_emit, w_term;
  logic [7:0]    w_byte, w_tok_data;
  logic          w_tok_wc, w_tok_eol, w_tok_err;
  logic          w_in_word_next, w_last_cr_next, w_trunc_next;
  logic [LW-1:0] w_len_next;

  // Output register is free when empty or being handed off this cycle.
  assign w_pop  = i_en && (r_count != '0) && ((r_state == S_EMPTY) || i_next);
  assign w_push = i_rx_valid && ((r_count != CNT_FULL) || w_pop);
  assign w_byte = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (i_rx_valid && !w_push) r_overflow <= 1'b1;
    end
  end

  // Classify the byte at the FIFO head; results only take effect on a pop.
  always_comb begin
    w_tok_wc       = 1'b0;
    w_tok_eol      = 1'b0;
    w_in_word_next = r_in_word;
    w_len_next     = r_len;
    w_trunc_next   = r_trunc;
    w_last_cr_next = (w_byte == 8'h0D);
    w_emit         = 1'b0;
`ifdef TOKENIZER_COMMENT_EN
    w_comment_next = r_comment;
    if (w_byte == 8'h0D || w_byte == 8'h0A) w_comment_next = 1'b0;
`endif
    if (w_byte == 8'h0D) begin
      w_tok_eol = 1'b1;
    end else if (w_byte == 8'h0A) begin
      w_tok_eol = !r_last_cr;
    end
`ifdef TOKENIZER_COMMENT_EN
    else if (r_comment) begin
      w_emit = 1'b0;
    end else if (w_byte == 8'h5C && !r_in_word) begin
      w_comment_next = 1'b1;
    end
`endif
    else if (w_byte == 8'h20 || w_byte == 8'h09) begin
      w_tok_wc = r_in_word;
    end else if (w_byte < 8'h20 || w_byte == 8'h7F) begin
      w_emit = 1'b0;
    end else begin
      w_in_word_next = 1'b1;
      if (r_len < LEN_MAX) begin
        w_emit     = 1'b1;
        w_len_next = r_len + LW'(1);
      end else begin
        w_trunc_next = 1'b1;
      end
    end
    w_term     = w_tok_wc || w_tok_eol;
    w_tok_err  = w_term && r_trunc;
    w_tok_data = w_tok_eol ? 8'h0A : (w_tok_wc ? 8'h20 : w_byte);
    if (w_term) begin
      w_emit         = 1'b1;
      w_in_word_next = 1'b0;
      w_len_next     = '0;
      w_trunc_next   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_word <= 1'b0;
      r_len     <= '0;
      r_last_cr <= 1'b0;
      r_trunc   <= 1'b0;
`ifdef TOKENIZER_COMMENT_EN
      r_comment <= 1'b0;
`endif
    end else if (w_pop) begin
      r_in_word <= w_in_word_next;
      r_len     <= w_len_next;
      r_last_cr <= w_last_cr_next;
      r_trunc   <= w_trunc_next;
`ifdef TOKENIZER_COMMENT_EN
      r_comment <= w_comment_next;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_EMPTY;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_pop && w_emit) w_state_next = S_FULL;
      S_FULL:  if (i_next) w_state_next = (w_pop && w_emit) ? S_FULL : S_EMPTY;
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= 8'h00;
      r_wc   <= 1'b0;
      r_eol  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_pop && w_emit) begin
      r_data <= w_tok_data;
      r_wc   <= w_tok_wc;
      r_eol  <= w_tok_eol;
      r_err  <= w_tok_err;
    end
  end

  always_comb begin
    o_ready    = (r_state == S_FULL);
    o_data     = r_data;
    o_wc       = r_wc;
    o_eol      = r_eol;
    o_err      = r_err;
    o_overflow = r_overflow;
  end
endmodule
